// File: rtl/alu_pkg.sv
// Shared definitions for the ALU result path: op codes, default widths,
// the writeback state encoding and the per-op write count helper.
package alu_pkg;

    localparam int DATA_W_DEF = 16;
    localparam int ADDR_W_DEF = 4;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_MUL = 3'b010;
    localparam logic [2:0] ALU_DIV = 3'b011;
    localparam logic [2:0] ALU_MOV = 3'b100;
    localparam logic [2:0] ALU_SWP = 3'b101;
    localparam logic [2:0] ALU_AND = 3'b110;
    localparam logic [2:0] ALU_OR  = 3'b111;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WR_OP1 = 2'd1,
        WR_OP2 = 2'd2,
        WR_R15 = 2'd3
    } wb_state_t;

    // Number of register file writes a bundle with this op code produces.
    function automatic logic [1:0] writes_needed(input logic [2:0] sel);
        case (sel)
            ALU_MUL, ALU_DIV, ALU_SWP: return 2'd2;
            default:                   return 2'd1;
        endcase
    endfunction

endpackage

// File: rtl/alu_writeback.sv
// alu_writeback: sequences one ALU result bundle into the single register
// file write port, one write per cycle, back-pressuring execute while a
// two-write bundle (mul/div high half or remainder, swap) drains.
// Optional feature macro: ALU_WB_BYPASS_EN -- when defined, a bundle accepted
// in IDLE has its op1 write driven combinationally in the acceptance cycle.
module alu_writeback
    import alu_pkg::*;
#(
    parameter int DATA_W      = DATA_W_DEF,
    parameter int ADDR_W      = ADDR_W_DEF,
    parameter int SPECIAL_REG = 15
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        in_sel,
    input  logic [ADDR_W-1:0] in_op1_addr,
    input  logic [ADDR_W-1:0] in_op2_addr,
    input  logic [DATA_W-1:0] in_op1data,
    input  logic [DATA_W-1:0] in_op2data,
    input  logic [DATA_W-1:0] in_r15,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic              busy
);

    localparam logic [ADDR_W-1:0] SPECIAL_ADDR = ADDR_W'(SPECIAL_REG);

    wb_state_t         state_q, state_d;
    logic [2:0]        sel_q;
    logic [ADDR_W-1:0] op1_addr_q, op2_addr_q;
    logic [DATA_W-1:0] op1data_q, op2data_q, r15_q;
    logic              accept;

    // State that follows the op1 write of a bundle: its second write, or IDLE.
    function automatic wb_state_t tail_state(input logic [2:0] sel);
        case (sel)
            ALU_MUL, ALU_DIV: return WR_R15;
            ALU_SWP:          return WR_OP2;
            default:          return IDLE;
        endcase
    endfunction

    // Ready when idle or when the write now on the port is the bundle's last.
    always_comb begin
        case (state_q)
            IDLE:           in_ready = 1'b1;
            WR_OP1:         in_ready = (writes_needed(sel_q) == 2'd1);
            WR_OP2, WR_R15: in_ready = 1'b1;
            default:        in_ready = 1'b0;
        endcase
        accept = in_valid && in_ready;
        busy   = (state_q != IDLE);
    end

    // State register; reset drops any pending writes.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Holding registers capture the whole bundle on acceptance only.
    always_ff @(posedge clk) begin
        if (accept) begin
            sel_q      <= in_sel;
            op1_addr_q <= in_op1_addr;
            op2_addr_q <= in_op2_addr;
            op1data_q  <= in_op1data;
            op2data_q  <= in_op2data;
            r15_q      <= in_r15;
        end
    end

    // Next-state: walk the bundle's write list, chaining a new bundle into
    // WR_OP1 when it is accepted on the last write.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
`ifdef ALU_WB_BYPASS_EN
                    state_d = tail_state(in_sel);
`else
                    state_d = WR_OP1;
`endif
                end
            end
            WR_OP1: begin
                state_d = tail_state(sel_q);
                if (state_d == IDLE && accept) begin
                    state_d = WR_OP1;
                end
            end
            WR_OP2, WR_R15: begin
                state_d = accept ? WR_OP1 : IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs: each write state drives one write from the held bundle; the
    // r15 and op2 writes come last so they win on address collisions.
    always_comb begin
        wr_en   = 1'b0;
        wr_addr = '0;
        wr_data = '0;
        case (state_q)
            WR_OP1: begin
                wr_en   = 1'b1;
                wr_addr = op1_addr_q;
                wr_data = op1data_q;
            end
            WR_OP2: begin
                wr_en   = 1'b1;
                wr_addr = op2_addr_q;
                wr_data = op2data_q;
            end
            WR_R15: begin
                wr_en   = 1'b1;
                wr_addr = SPECIAL_ADDR;
                wr_data = r15_q;
            end
            default: begin
`ifdef ALU_WB_BYPASS_EN
                if (accept) begin
                    wr_en   = 1'b1;
                    wr_addr = in_op1_addr;
                    wr_data = in_op1data;
                end
`endif
            end
        endcase
    end

endmodule

// File: tb/tb_alu_writeback.sv
// Self-checking bench for alu_writeback: directed table of bundles, hand
// sequences for back-to-back / reset corner cases, and a random phase, all
// compared against a queue-of-pending-writes reference model.
module tb_alu_writeback;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  in_sel;
    logic [3:0]  in_op1_addr, in_op2_addr;
    logic [15:0] in_op1data, in_op2data, in_r15;
    logic        wr_en;
    logic [3:0]  wr_addr;
    logic [15:0] wr_data;
    logic        busy;

    always #5 clk = ~clk;

    alu_writeback #(.DATA_W(16), .ADDR_W(4), .SPECIAL_REG(15)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_sel(in_sel), .in_op1_addr(in_op1_addr), .in_op2_addr(in_op2_addr),
        .in_op1data(in_op1data), .in_op2data(in_op2data), .in_r15(in_r15),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .busy(busy)
    );

    typedef struct {
        logic [2:0]  sel;
        logic [3:0]  a1, a2;
        logic [15:0] d1, d2, r15;
    } bundle_t;

    typedef struct {
        logic [3:0]  addr;
        logic [15:0] data;
    } wr_t;

    typedef struct {
        bundle_t     b;
        int          nwr;
        logic [3:0]  w0a, w1a;
        logic [15:0] w0d, w1d;
    } vec_t;

    wr_t     exp_q[$];
    bundle_t cur;
    int      checks = 0;
    int      errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive(input bundle_t b, input logic v);
        cur         = b;
        in_valid    = v;
        in_sel      = b.sel;
        in_op1_addr = b.a1;
        in_op2_addr = b.a2;
        in_op1data  = b.d1;
        in_op2data  = b.d2;
        in_r15      = b.r15;
    endtask

    // Reference: a bundle expands to its ordered list of writes.
    function automatic void model_push(bundle_t b);
        wr_t w;
        w.addr = b.a1; w.data = b.d1;
        exp_q.push_back(w);
        if (b.sel == 3'b010 || b.sel == 3'b011) begin
            w.addr = 4'd15; w.data = b.r15;
            exp_q.push_back(w);
        end else if (b.sel == 3'b101) begin
            w.addr = b.a2; w.data = b.d2;
            exp_q.push_back(w);
        end
    endfunction

    task automatic check_outputs(input string tag);
        chk({tag, " wr_en"},    32'(wr_en),    32'(exp_q.size() > 0));
        chk({tag, " busy"},     32'(busy),     32'(exp_q.size() > 0));
        chk({tag, " in_ready"}, 32'(in_ready), 32'(exp_q.size() <= 1));
        if (exp_q.size() > 0) begin
            chk({tag, " wr_addr"}, 32'(wr_addr), 32'(exp_q[0].addr));
            chk({tag, " wr_data"}, 32'(wr_data), 32'(exp_q[0].data));
        end
    endtask

    // One clock: decide acceptance from the model, advance, compare.
    task automatic cycle(input string tag, output bit acc);
        acc = rst_n && in_valid && (exp_q.size() <= 1);
        @(posedge clk);
        #1;
        if (!rst_n) begin
            exp_q.delete();
        end else begin
            if (exp_q.size() > 0) void'(exp_q.pop_front());
            if (acc) model_push(cur);
        end
        check_outputs(tag);
    endtask

    function automatic bundle_t mkb(input logic [2:0] sel, input logic [3:0] a1, input logic [3:0] a2,
                                    input logic [15:0] d1, input logic [15:0] d2, input logic [15:0] r15);
        bundle_t b;
        b.sel = sel; b.a1 = a1; b.a2 = a2; b.d1 = d1; b.d2 = d2; b.r15 = r15;
        return b;
    endfunction

    function automatic vec_t mkv(input bundle_t b, input int nwr, input logic [3:0] w0a, input logic [15:0] w0d,
                                 input logic [3:0] w1a, input logic [15:0] w1d);
        vec_t v;
        v.b = b; v.nwr = nwr; v.w0a = w0a; v.w0d = w0d; v.w1a = w1a; v.w1d = w1d;
        return v;
    endfunction

    function automatic bundle_t rand_bundle();
        return mkb(3'($urandom_range(0, 7)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                   16'($urandom), 16'($urandom), 16'($urandom));
    endfunction

    vec_t tab[9];

    initial begin
        bit acc;
        bit pending;
        bundle_t junk;

        tab[0] = mkv(mkb(3'b000, 4'd3, 4'd0, 16'h0007, 16'h0000, 16'h0000), 1, 4'd3,  16'h0007, 4'd0,  16'h0000);
        tab[1] = mkv(mkb(3'b010, 4'd2, 4'd0, 16'h2000, 16'h0000, 16'h0001), 2, 4'd2,  16'h2000, 4'd15, 16'h0001);
        tab[2] = mkv(mkb(3'b101, 4'd4, 4'd4, 16'hAAAA, 16'h5555, 16'h0000), 2, 4'd4,  16'hAAAA, 4'd4,  16'h5555);
        tab[3] = mkv(mkb(3'b011, 4'd15, 4'd0, 16'h1234, 16'h0000, 16'h0BCD), 2, 4'd15, 16'h1234, 4'd15, 16'h0BCD);
        tab[4] = mkv(mkb(3'b101, 4'd1, 4'd9, 16'h1111, 16'h9999, 16'h0000), 2, 4'd1,  16'h1111, 4'd9,  16'h9999);
        tab[5] = mkv(mkb(3'b110, 4'd7, 4'd8, 16'h00F0, 16'hFFFF, 16'hEEEE), 1, 4'd7,  16'h00F0, 4'd0,  16'h0000);
        tab[6] = mkv(mkb(3'b100, 4'd0, 4'd5, 16'hFFFF, 16'h1234, 16'h4321), 1, 4'd0,  16'hFFFF, 4'd0,  16'h0000);
        tab[7] = mkv(mkb(3'b111, 4'd14, 4'd3, 16'h8001, 16'h0000, 16'h7777), 1, 4'd14, 16'h8001, 4'd0,  16'h0000);
        tab[8] = mkv(mkb(3'b001, 4'd5, 4'd6, 16'h0000, 16'hABCD, 16'hDCBA), 1, 4'd5,  16'h0000, 4'd0,  16'h0000);

        // Reset held for 3 cycles with a valid bundle present.
        rst_n = 1'b0;
        drive(tab[1].b, 1'b1);
        for (int i = 0; i < 3; i++) begin
            cycle("reset", acc);
            chk("reset wr_addr", 32'(wr_addr), 32'd0);
            chk("reset wr_data", 32'(wr_data), 32'd0);
        end
        drive(tab[1].b, 1'b0);
        rst_n = 1'b1;
        cycle("post-reset", acc);
        chk("post-reset in_ready", 32'(in_ready), 32'd1);

        // Directed table: each bundle from idle, explicit write sequence.
        for (int k = 0; k < 9; k++) begin
            drive(tab[k].b, 1'b1);
            cycle("table accept", acc);
            chk("table accepted", 32'(acc), 32'd1);
            junk = tab[k].b;
            junk.d1 = ~junk.d1; junk.d2 = ~junk.d2; junk.r15 = ~junk.r15;
            junk.a1 = junk.a1 ^ 4'h5; junk.a2 = junk.a2 ^ 4'hA;
            drive(junk, 1'b0);
            chk("table w0 en",    32'(wr_en),    32'd1);
            chk("table w0 addr",  32'(wr_addr),  32'(tab[k].w0a));
            chk("table w0 data",  32'(wr_data),  32'(tab[k].w0d));
            chk("table w0 ready", 32'(in_ready), 32'(tab[k].nwr == 1));
            if (tab[k].nwr == 2) begin
                cycle("table second", acc);
                chk("table w1 en",    32'(wr_en),    32'd1);
                chk("table w1 addr",  32'(wr_addr),  32'(tab[k].w1a));
                chk("table w1 data",  32'(wr_data),  32'(tab[k].w1d));
                chk("table w1 ready", 32'(in_ready), 32'd1);
            end
            cycle("table drain", acc);
            chk("table idle en", 32'(wr_en), 32'd0);
        end

        // Back-to-back: 4 adds, div, add with no bubble.
        for (int i = 0; i < 4; i++) begin
            drive(mkb(3'b000, 4'(i + 8), 4'd0, 16'(16'h0100 + i), 16'h0, 16'h0), 1'b1);
            cycle("b2b add", acc);
            chk("b2b add accepted", 32'(acc), 32'd1);
            chk("b2b add addr", 32'(wr_addr), 32'(i + 8));
        end
        drive(mkb(3'b011, 4'd6, 4'd0, 16'h0003, 16'h0, 16'h0001), 1'b1);
        cycle("b2b div", acc);
        chk("b2b div op1 addr", 32'(wr_addr), 32'd6);
        chk("b2b div op1 data", 32'(wr_data), 32'h0003);
        chk("b2b div ready", 32'(in_ready), 32'd0);
        drive(mkb(3'b000, 4'd12, 4'd0, 16'hBEEF, 16'h0, 16'h0), 1'b1);
        cycle("b2b r15", acc);
        chk("b2b r15 addr", 32'(wr_addr), 32'd15);
        chk("b2b r15 data", 32'(wr_data), 32'h0001);
        chk("b2b r15 ready", 32'(in_ready), 32'd1);
        cycle("b2b last add", acc);
        chk("b2b last add accepted", 32'(acc), 32'd1);
        drive(cur, 1'b0);
        chk("b2b last add en", 32'(wr_en), 32'd1);
        chk("b2b last add data", 32'(wr_data), 32'hBEEF);
        cycle("b2b drain", acc);

        // Reset during WR_OP1 of a mul: the r15 write must never appear.
        drive(mkb(3'b010, 4'd2, 4'd0, 16'h2000, 16'h0, 16'h0001), 1'b1);
        cycle("midrst accept", acc);
        drive(cur, 1'b0);
        chk("midrst op1 addr", 32'(wr_addr), 32'd2);
        rst_n = 1'b0;
        cycle("midrst in reset", acc);
        chk("midrst no write", 32'(wr_en), 32'd0);
        rst_n = 1'b1;
        cycle("midrst released", acc);
        chk("midrst no r15", 32'(wr_en), 32'd0);
        chk("midrst idle ready", 32'(in_ready), 32'd1);

        // Random traffic with upstream hold and occasional resets.
        pending = 1'b0;
        for (int n = 0; n < 3000; n++) begin
            if (!pending) begin
                drive(rand_bundle(), 1'($urandom_range(0, 9) < 7));
            end
            rst_n = ($urandom_range(0, 199) != 0);
            cycle("random", acc);
            pending = in_valid && !acc && rst_n;
        end
        rst_n = 1'b1;
        drive(cur, 1'b0);
        for (int i = 0; i < 3; i++) cycle("final drain", acc);
        chk("final idle busy", 32'(busy), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
